router_src_arb: RTL

Round-robin input scheduler in front of `router_top`. It shares the router's single byte-wide packet input between NUM_SRC packet sources, granting one whole packet at a time. It tracks packet boundaries from the header length field and drives `packet_valid` low on the parity byte. It holds the presented byte while the router asserts `busy`, discards packets addressed to the invalid port 3, and inserts a minimum inter-packet gap.

---
 rtl/router_pkg.sv | 30 +++
 rtl/router_src_arb_rr_pick.sv | 35 +++
 rtl/router_src_arb.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and header field layout for the router input scheduler.
// Header byte is {len[7:2], addr[1:0]}; addr 3 never reaches the router.
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_PAR,
        ST_DRN,
        ST_GAP,
        ST_DROP
    } state_t;

    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
    localparam int ADDR_W  = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/router_src_arb_rr_pick.sv
// Combinational round-robin search: the first requester strictly after
// 'last', wrapping around, with 'last' itself checked at lowest priority.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick_oh,
    output logic [IW-1:0] pick_idx,
    output logic          pick_any
);

    logic [IW-1:0] cand [N];

    // cand[gi] is the source visited gi+1 steps after 'last'
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand[gi] = IW'((int'(last) + 1 + gi) % N);
    end

    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                pick_oh           = '0;
                pick_oh[cand[k]]  = 1'b1;
                pick_idx          = cand[k];
                pick_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_src_arb.sv
// Round-robin packet scheduler sharing the router's byte input between
// NUM_SRC sources, one whole packet per grant, with drop and gap handling.
module router_src_arb
    import router_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IFG     = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_ready,
    input  logic                 busy,
    output logic [7:0]           data_in,
    output logic                 packet_valid,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 drop_pulse,
    output logic                 proto_err
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    state_t             state_q;
    logic [IW-1:0]      g_q;
    logic [IW-1:0]      last_q;
    logic [NUM_SRC-1:0] grant_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [3:0]         gap_q;
    logic               out_vld_q;
    logic               out_pv_q;
    logic [7:0]         out_data_q;
    logic               drop_pulse_q;
    logic               proto_err_q;

    logic [NUM_SRC-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    logic [7:0] sel_data;
    logic       sel_valid;
    logic       xfer_state;
    logic       ld;
    logic       cons;
    logic       hdr_drop;
    logic       load_out;
    logic       underrun;
    logic [3:0] gap_dec;

    rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_pick (
        .req      (src_valid),
        .last     (last_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    assign sel_data   = src_data[8*g_q +: 8];
    assign sel_valid  = src_valid[g_q];
    assign xfer_state = (state_q == ST_HDR) || (state_q == ST_PAY) || (state_q == ST_PAR);
    assign cons       = out_vld_q && !busy;
    assign ld         = xfer_state && sel_valid && (!out_vld_q || !busy);
    assign hdr_drop   = (state_q == ST_HDR) && (hdr_addr(sel_data) == ADDR_INVALID);
    assign load_out   = ld && !hdr_drop;
    // The output register is about to run dry while the owner has nothing to give
    assign underrun   = ((state_q == ST_PAY) || (state_q == ST_PAR)) && !sel_valid
                        && (cons || !out_vld_q);
    assign gap_dec    = gap_q - 4'd1;

    always_comb begin
        src_ready = '0;
        if (xfer_state) begin
            src_ready[g_q] = ld;
        end else if (state_q == ST_DROP) begin
            src_ready[g_q] = sel_valid;
        end
    end

    assign data_in      = out_vld_q ? out_data_q : 8'h00;
    assign packet_valid = out_vld_q && out_pv_q;
    assign grant        = grant_q;
    assign drop_pulse   = drop_pulse_q;
    assign proto_err    = proto_err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            g_q          <= '0;
            last_q       <= IW'(NUM_SRC - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            out_vld_q    <= 1'b0;
            out_pv_q     <= 1'b0;
            out_data_q   <= 8'h00;
            drop_pulse_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            drop_pulse_q <= 1'b0;
            if (underrun) begin
                proto_err_q <= 1'b1;
            end

            if (load_out) begin
                out_vld_q  <= 1'b1;
                out_data_q <= sel_data;
                out_pv_q   <= (state_q != ST_PAR);
            end else if (cons) begin
                out_vld_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        g_q     <= pick_idx;
                        grant_q <= pick_oh;
                        last_q  <= pick_idx;
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (ld) begin
                        cnt_q <= hdr_len(sel_data);
                        if (hdr_drop) begin
                            state_q <= ST_DROP;
                        end else if (hdr_len(sel_data) == '0) begin
                            state_q <= ST_PAR;
                        end else begin
                            state_q <= ST_PAY;
                        end
                    end
                end
                ST_PAY: begin
                    if (ld) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= ST_PAR;
                        end
                    end
                end
                ST_PAR: begin
                    if (ld) begin
                        state_q <= ST_DRN;
                    end
                end
                ST_DRN: begin
                    if (cons) begin
                        gap_q   <= 4'(IFG);
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_q <= gap_dec;
                    if (gap_dec == 4'd0) begin
                        grant_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    // cnt_q counts the bytes still owed after this one: len+1 in total
                    if (sel_valid) begin
                        if (cnt_q == '0) begin
                            drop_pulse_q <= 1'b1;
                            grant_q      <= '0;
                            state_q      <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
